dsp_skid_reg: RTL and testbench

//  Two-entry valid/ready pipeline stage (skid buffer) for the DSP datapath. It is the

---
 rtl/dsp_skid_reg.sv | 128 ++++++++++++
 tb/tb_dsp_skid_reg.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dsp_skid_reg.sv
// Two-entry valid/ready skid buffer for the DSP datapath; all outputs are registered.
// Define DSP_SKID_STATS_EN to add the saturating stall_cnt output and its CNT_WIDTH parameter.
module dsp_skid_reg #(
  parameter int WIDTH = 18
`ifdef DSP_SKID_STATS_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef DSP_SKID_STATS_EN
  , output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             m_valid_q, m_valid_d;
  logic             s_ready_q, s_ready_d;
  logic             in_xfer, out_xfer;

  assign in_xfer  = s_valid & s_ready_q;
  assign out_xfer = m_valid_q & m_ready;

  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_d    = skid_q;
    m_valid_d = m_valid_q;
    s_ready_d = s_ready_q;
    // Flush outranks any handshake; main_q keeps its value so m_data does not glitch to zero.
    if (flush) begin
      state_d   = ST_EMPTY;
      m_valid_d = 1'b0;
      s_ready_d = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_d    = s_data;
            state_d   = ST_BUSY;
            m_valid_d = 1'b1;
          end
        end
        ST_BUSY: begin
          if (in_xfer && out_xfer) begin
            main_d = s_data;
          end else if (in_xfer) begin
            skid_d    = s_data;
            state_d   = ST_FULL;
            s_ready_d = 1'b0;
          end else if (out_xfer) begin
            state_d   = ST_EMPTY;
            m_valid_d = 1'b0;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            main_d    = skid_q;
            state_d   = ST_BUSY;
            s_ready_d = 1'b1;
          end
        end
        default: begin
          state_d   = ST_EMPTY;
          m_valid_d = 1'b0;
          s_ready_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      m_valid_q <= 1'b0;
      s_ready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      m_valid_q <= m_valid_d;
      s_ready_q <= s_ready_d;
    end
  end

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = main_q;

`ifdef DSP_SKID_STATS_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      stall_cnt_d = '0;
    end else if (m_valid_q && !m_ready && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dsp_skid_reg.sv
// Scoreboard bench for dsp_skid_reg: accepted words are queued, a negedge monitor checks outputs.
// Build with DSP_SKID_STATS_EN to also exercise stall_cnt (CNT_WIDTH=4).
module tb_dsp_skid_reg;
  localparam int W = 18;
`ifdef DSP_SKID_STATS_EN
  localparam int CW = 4;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] s_data = '0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_data;
`ifdef DSP_SKID_STATS_EN
  logic [CW-1:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  dsp_skid_reg #(
    .WIDTH(W)
`ifdef DSP_SKID_STATS_EN
    , .CNT_WIDTH(CW)
`endif
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data)
`ifdef DSP_SKID_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  // Reference model: the queue holds exactly the words the stage currently stores.
  logic [W-1:0] q[$];
  logic [W-1:0] last_head = '0;
  logic         pend_push = 1'b0;
  logic         pend_flush = 1'b0;
  logic [W-1:0] pend_data = '0;
`ifdef DSP_SKID_STATS_EN
  int cnt_model = 0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Bookkeeping applied at the edge where the DUT commits the handshake.
  always @(posedge clk) begin
    if (rst_n) begin
      if (pend_flush) q.delete();
      else if (pend_push) q.push_back(pend_data);
    end
    pend_push  = 1'b0;
    pend_flush = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic         exp_valid;
      logic [W-1:0] exp_data;
      exp_valid = (q.size() > 0);
      exp_data  = exp_valid ? q[0] : last_head;
      chk("m_valid", {31'd0, m_valid}, {31'd0, exp_valid});
      chk("s_ready", {31'd0, s_ready}, {31'd0, q.size() < 2});
      chk("m_data", 32'(m_data), 32'(exp_data));
      if (exp_valid) last_head = q[0];
      if (exp_valid && m_ready) begin
        $display("OUT data=%05h", q[0]);
        void'(q.pop_front());
        n_out++;
      end
`ifdef DSP_SKID_STATS_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(cnt_model));
      if (flush) cnt_model = 0;
      else if (exp_valid && !m_ready && cnt_model < (1 << CW) - 1) cnt_model++;
`endif
    end
  end

  task automatic step(input logic sv, input logic [W-1:0] sd, input logic mr, input logic fl);
    @(posedge clk);
    #1;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
    @(negedge clk);
    pend_flush = fl;
    pend_push  = sv && s_ready && !fl;
    pend_data  = sd;
    if (pend_push) $display("IN  data=%05h", sd);
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    int sent;
    int cyc;
    logic [W-1:0] d;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("rst_m_data", 32'(m_data), 32'd0);
    rst_n = 1'b1;

    // Stream 1..5 with the consumer always ready.
    for (int i = 1; i <= 5; i++) step(1'b1, W'(i), 1'b1, 1'b0);
    drain();

    // Backpressure into FULL; 0xC must wait until a slot frees.
    step(1'b1, 18'hA, 1'b0, 1'b0);
    step(1'b1, 18'hB, 1'b0, 1'b0);
    step(1'b1, 18'hC, 1'b0, 1'b0);
    chk("full_s_ready", {31'd0, s_ready}, 32'd0);
    step(1'b1, 18'hC, 1'b0, 1'b0);
    step(1'b1, 18'hC, 1'b1, 1'b0);
    step(1'b1, 18'hC, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    drain();

    // Flush while FULL with a concurrent valid input that must be discarded.
    step(1'b1, 18'hA, 1'b0, 1'b0);
    step(1'b1, 18'hB, 1'b0, 1'b0);
    step(1'b1, 18'hD, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("flush_m_valid", {31'd0, m_valid}, 32'd0);
    chk("flush_s_ready", {31'd0, s_ready}, 32'd1);
    drain();

    // Randomised traffic, 1000 words.
    n_out = 0;
    sent  = 0;
    cyc   = 0;
    while (n_out < 1000 && cyc < 20000) begin
      d = W'($urandom());
      step((sent < 1000) && ($urandom_range(1) == 1), d, $urandom_range(1) == 1, 1'b0);
      if (pend_push) sent++;
      cyc++;
    end
    chk("rand_out_count", 32'(n_out), 32'd1000);
    drain();

    // Asynchronous reset in the middle of a stream.
    for (int i = 16; i < 20; i++) step(1'b1, W'(i), 1'b1, 1'b0);
    @(posedge clk);
    #3;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    q.delete();
    pend_push  = 1'b0;
    pend_flush = 1'b0;
    last_head  = '0;
`ifdef DSP_SKID_STATS_EN
    cnt_model = 0;
`endif
    #1;
    chk("arst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("arst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("arst_m_data", 32'(m_data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 32; i < 36; i++) step(1'b1, W'(i), 1'b1, 1'b0);
    drain();

`ifdef DSP_SKID_STATS_EN
    step(1'b1, 18'h5, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0);
    chk("stall_sat", 32'(stall_cnt), 32'd15);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("stall_flush", 32'(stall_cnt), 32'd0);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
